// File: rtl/rx_bridge_pkg.sv
// Shared types and constants for the MAC-to-decoder receive bridge.
package rx_bridge_pkg;

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic              tlast;
    logic [BEAT_W-1:0] tdata;
  } beat_t;

endpackage

// File: rtl/rx_bridge_if.sv
// MAC RX stream and decoder stream signals of the receive bridge.
interface rx_bridge_if;
  import rx_bridge_pkg::*;

  logic [BEAT_W-1:0] mac_tdata;
  logic              mac_tvalid;
  logic              mac_tlast;
  logic              mac_tuser;
  logic [BEAT_W-1:0] dec_tdata;
  logic              dec_tvalid;
  logic              dec_tlast;
  logic              dec_tready;

  modport master (
    output mac_tdata, mac_tvalid, mac_tlast, mac_tuser, dec_tready,
    input  dec_tdata, dec_tvalid, dec_tlast
  );

  modport slave (
    input  mac_tdata, mac_tvalid, mac_tlast, mac_tuser, dec_tready,
    output dec_tdata, dec_tvalid, dec_tlast
  );
endinterface

// File: rtl/rx_frame_fifo.sv
// Store-and-forward frame FIFO: beats become readable only once committed,
// and an uncommitted frame can be rolled back in one cycle.
module rx_frame_fifo
  import rx_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  beat_t push_beat,
  input  logic  commit,
  input  logic  rollback,
  input  logic  pop,
  output logic  full_c,
  output logic  rd_valid_c,
  output beat_t rd_beat_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  beat_t         mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
  logic [PW-1:0] used_c;
  logic          wr_en_c;

  // Read mux is gated so the outputs are zero whenever nothing is committed.
  always_comb begin
    used_c     = wr_q - rd_q;
    full_c     = (used_c == PW'(DEPTH));
    rd_valid_c = (rd_q != commit_q);
    rd_beat_c  = rd_valid_c ? mem_q[rd_q[AW-1:0]] : '0;
    wr_en_c    = push && !full_c;
  end

  // Rollback wins over push so an errored last beat leaves nothing behind.
  always_comb begin
    wr_d     = wr_q;
    commit_d = commit_q;
    rd_d     = rd_q;
    if (wr_en_c)              wr_d     = wr_q + PW'(1);
    if (commit && wr_en_c)    commit_d = wr_q + PW'(1);
    if (rollback)             wr_d     = commit_q;
    if (pop && rd_valid_c)    rd_d     = rd_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      commit_q <= '0;
      rd_q     <= '0;
    end else begin
      wr_q     <= wr_d;
      commit_q <= commit_d;
      rd_q     <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_q[AW-1:0]] <= push_beat;
  end

endmodule

// File: rtl/rx_bridge.sv
// Receive bridge: MAC RX beats -> frame FIFO -> decoder, dropping bad frames whole.
// Optional frame/drop statistics are built when RX_BRIDGE_STATS_EN is defined.
module rx_bridge
  import rx_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rx_bridge_if.slave       bus,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count
);

  wr_state_e state_q, state_d;
  logic      push_c, commit_c, rollback_c;
  logic      full_c, rd_valid_c;
  beat_t     wr_beat_c, rd_beat_c;

  assign wr_beat_c = '{tlast: bus.mac_tlast, tdata: bus.mac_tdata};

  // Write FSM; SYNC swallows the tail of a frame cut by reset.
  always_comb begin
    state_d    = state_q;
    push_c     = 1'b0;
    commit_c   = 1'b0;
    rollback_c = 1'b0;
    unique case (state_q)
      ST_SYNC: begin
        if (!bus.mac_tvalid || bus.mac_tlast) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (bus.mac_tvalid) begin
          if (!full_c) begin
            push_c = 1'b1;
            if (bus.mac_tlast) begin
              commit_c   = !bus.mac_tuser;
              rollback_c = bus.mac_tuser;
            end
          end else begin
            rollback_c = 1'b1;
            if (!bus.mac_tlast) state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (bus.mac_tvalid && bus.mac_tlast) state_d = ST_RECV;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SYNC;
    else        state_q <= state_d;
  end

  rx_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_beat (wr_beat_c),
    .commit    (commit_c),
    .rollback  (rollback_c),
    .pop       (bus.dec_tready),
    .full_c    (full_c),
    .rd_valid_c(rd_valid_c),
    .rd_beat_c (rd_beat_c)
  );

  assign bus.dec_tvalid = rd_valid_c;
  assign bus.dec_tdata  = rd_beat_c.tdata;
  assign bus.dec_tlast  = rd_beat_c.tlast;

`ifdef RX_BRIDGE_STATS_EN
  // Every rollback is exactly one dropped frame; every commit one good frame.
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (commit_c && (frame_cnt_q != '1))  frame_cnt_d = frame_cnt_q + CNT_W'(1);
    if (rollback_c && (drop_cnt_q != '1)) drop_cnt_d  = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_rx_bridge.sv
// Directed self-checking bench for rx_bridge (works with or without RX_BRIDGE_STATS_EN).
module tb_rx_bridge;
  import rx_bridge_pkg::*;

  localparam int unsigned DEPTH = 16;
`ifdef RX_BRIDGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] frame_count, drop_count;

  rx_bridge_if bus();

  rx_bridge #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .frame_count(frame_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] rx_q[$];
  logic [64:0] exp_q[$];
  logic        prev_stall;
  logic [64:0] prev_beat;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] cnt_exp(input int n);
    return STATS ? 65'(n) : 65'(0);
  endfunction

  // Capture accepted beats and check data holds while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_beat  <= '0;
    end else begin
      if (prev_stall && bus.dec_tvalid)
        check("hold", {bus.dec_tlast, bus.dec_tdata}, prev_beat);
      if (bus.dec_tvalid && bus.dec_tready)
        rx_q.push_back({bus.dec_tlast, bus.dec_tdata});
      prev_stall <= bus.dec_tvalid && !bus.dec_tready;
      prev_beat  <= {bus.dec_tlast, bus.dec_tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mac_beat(input logic [63:0] d, input logic l, input logic u);
    bus.mac_tvalid = 1'b1;
    bus.mac_tdata  = d;
    bus.mac_tlast  = l;
    bus.mac_tuser  = u;
    tick();
    bus.mac_tvalid = 1'b0;
    bus.mac_tlast  = 1'b0;
    bus.mac_tuser  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] base, input int n, input logic u, input bit deliver);
    for (int i = 0; i < n; i++) begin
      mac_beat(base + 64'(i), (i == n - 1), (i == n - 1) && u);
      if (deliver) exp_q.push_back({(i == n - 1), base + 64'(i)});
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.mac_tvalid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    int n;
    repeat (30) tick();
    check({tag, "_beats"}, 65'(rx_q.size()), 65'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_beat"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.mac_tvalid = 1'b0;
    bus.mac_tdata  = '0;
    bus.mac_tlast  = 1'b0;
    bus.mac_tuser  = 1'b0;
    bus.dec_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 65'(bus.dec_tvalid), 65'(0));
    check("rst_data",  65'(bus.dec_tdata),  65'(0));
    check("rst_last",  65'(bus.dec_tlast),  65'(0));
    check("rst_frames", 65'(frame_count), 65'(0));
    check("rst_drops",  65'(drop_count),  65'(0));
    rst_n = 1'b1;
    tick();

    // Basic 3-beat frame, first beat visible right after the last write.
    mac_beat(64'h11, 1'b0, 1'b0);
    mac_beat(64'h22, 1'b0, 1'b0);
    check("t1_hidden", 65'(bus.dec_tvalid), 65'(0));
    mac_beat(64'h33, 1'b1, 1'b0);
    check("t1_valid", 65'(bus.dec_tvalid), 65'(1));
    check("t1_first", {bus.dec_tlast, bus.dec_tdata}, {1'b0, 64'h11});
    exp_q.push_back({1'b0, 64'h11});
    exp_q.push_back({1'b0, 64'h22});
    exp_q.push_back({1'b1, 64'h33});
    drain("t1");
    check("t1_frames", 65'(frame_count), cnt_exp(1));
    check("t1_drops",  65'(drop_count),  cnt_exp(0));

    // FCS error frame dropped, following good frame passes.
    do_reset();
    send_frame(64'h200, 4, 1'b1, 1'b0);
    send_frame(64'h210, 2, 1'b0, 1'b1);
    drain("t2");
    check("t2_frames", 65'(frame_count), cnt_exp(1));
    check("t2_drops",  65'(drop_count),  cnt_exp(1));

    // Overflow: second 10-beat frame fills at beat 7 and is dropped.
    do_reset();
    bus.dec_tready = 1'b0;
    send_frame(64'h300, 10, 1'b0, 1'b1);
    send_frame(64'h400, 10, 1'b0, 1'b0);
    tick();
    check("t3_valid", 65'(bus.dec_tvalid), 65'(1));
    check("t3_head", {bus.dec_tlast, bus.dec_tdata}, {1'b0, 64'h300});
    bus.dec_tready = 1'b1;
    drain("t3");
    check("t3_frames", 65'(frame_count), cnt_exp(1));
    check("t3_drops",  65'(drop_count),  cnt_exp(1));

    // Oversize frame dropped whole, 1-beat frame after it passes.
    do_reset();
    send_frame(64'h500, 17, 1'b0, 1'b0);
    check("t4_empty", 65'(bus.dec_tvalid), 65'(0));
    send_frame(64'h600, 1, 1'b0, 1'b1);
    drain("t4");
    check("t4_frames", 65'(frame_count), cnt_exp(1));
    check("t4_drops",  65'(drop_count),  cnt_exp(1));

    // Reset during beat 2 of 5; the tail is absorbed without counting.
    do_reset();
    mac_beat(64'h701, 1'b0, 1'b0);
    bus.mac_tvalid = 1'b1;
    bus.mac_tdata  = 64'h702;
    #3 rst_n = 1'b0;
    tick();
    bus.mac_tdata = 64'h703;
    tick();
    rst_n = 1'b1;
    mac_beat(64'h704, 1'b0, 1'b0);
    mac_beat(64'h705, 1'b1, 1'b0);
    check("t5_valid",  65'(bus.dec_tvalid), 65'(0));
    check("t5_frames", 65'(frame_count), 65'(0));
    check("t5_drops",  65'(drop_count),  65'(0));
    send_frame(64'h800, 3, 1'b0, 1'b1);
    drain("t5");
    check("t5_frames_after", 65'(frame_count), cnt_exp(1));

    // Back-to-back frames with ready held high: no gap between frames.
    do_reset();
    mac_beat(64'h901, 1'b0, 1'b0);
    mac_beat(64'h902, 1'b1, 1'b0);
    check("t6_gap0", {bus.dec_tvalid, bus.dec_tlast, bus.dec_tdata[62:0]}, {1'b1, 1'b0, 63'h901});
    mac_beat(64'h903, 1'b0, 1'b0);
    check("t6_gap1", {bus.dec_tvalid, bus.dec_tlast, bus.dec_tdata[62:0]}, {1'b1, 1'b1, 63'h902});
    mac_beat(64'h904, 1'b1, 1'b0);
    check("t6_gap2", {bus.dec_tvalid, bus.dec_tlast, bus.dec_tdata[62:0]}, {1'b1, 1'b0, 63'h903});
    tick();
    check("t6_gap3", {bus.dec_tvalid, bus.dec_tlast, bus.dec_tdata[62:0]}, {1'b1, 1'b1, 63'h904});
    tick();
    check("t6_done", 65'(bus.dec_tvalid), 65'(0));
    exp_q.push_back({1'b0, 64'h901});
    exp_q.push_back({1'b1, 64'h902});
    exp_q.push_back({1'b0, 64'h903});
    exp_q.push_back({1'b1, 64'h904});
    drain("t6a");

    // Same two-frame pattern read out with ready toggling 1,0,1,0.
    bus.dec_tready = 1'b0;
    send_frame(64'hA01, 2, 1'b0, 1'b1);
    send_frame(64'hA11, 2, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bus.dec_tready = (i % 2 == 0);
      tick();
    end
    bus.dec_tready = 1'b1;
    drain("t6b");
    check("t6_frames", 65'(frame_count), cnt_exp(4));
    check("t6_drops",  65'(drop_count),  cnt_exp(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_bridge.md
# rx_bridge

Receive-side bridge between the network MAC RX stream and the market-data decoder. It buffers MAC beats in a store-and-forward frame FIFO and presents only complete, error-free frames to the decoder. Frames are dropped whole on FCS error, overflow or oversize. The block is the receive-path counterpart of the encoder-to-MAC transmit bridge and owns the only buffering between the MAC, which cannot be back-pressured, and the decoder.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO depth in 64-bit beats. Must be a power of 2 and at least 4. This is also the maximum frame length in beats.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mac_tdata`  in  64  MAC RX data beat.
- `mac_tvalid`  in  1  beat valid. There is no ready signal: the MAC never stalls.
- `mac_tlast`  in  1  last beat of the frame.
- `mac_tuser`  in  1  frame error (bad FCS). Sampled only on the `mac_tlast` beat.
- `dec_tdata`  out  64  beat to the decoder.
- `dec_tvalid`  out  1  beat available.
- `dec_tlast`  out  1  last beat of the frame.
- `dec_tready`  in  1  decoder accepts the beat.
- `frame_count`  out  16  frames committed. Saturating; stats only.
- `drop_count`  out  16  frames dropped. Saturating; stats only.

## Operation
- **Storage:** `DEPTH` entries of {tlast, tdata}.
- **Pointers:** `wr_ptr`, `commit_ptr` and `rd_ptr`, each log2(DEPTH)+1 bits wide, wrapping modulo 2·DEPTH.
  - Used space is `wr_ptr - rd_ptr`.
  - Full means used space equals DEPTH.
  - Full is computed from registered pointers only. A read in the same cycle does not free space for a write.
- **Write FSM states:** SYNC, RECV, DROP. The reset state is SYNC.
- **SYNC:**
  - `mac_tvalid` = 0 moves the FSM to RECV.
  - A valid beat with `mac_tlast` = 1 is discarded and moves the FSM to RECV.
  - Any other valid beat is discarded and the FSM stays in SYNC.
  - SYNC is never counted as a drop.
- **RECV, valid beat and FIFO not full:** write the beat at `wr_ptr`, then `wr_ptr` +1.
  - On `tlast` with `tuser` = 0: `commit_ptr` <= new `wr_ptr`, and `frame_count` +1.
  - On `tlast` with `tuser` = 1: `wr_ptr` <= `commit_ptr` (rollback), and `drop_count` +1.
- **RECV, valid beat and FIFO full:**
  - Roll back: `wr_ptr` <= `commit_ptr`, and `drop_count` +1.
  - If the beat is `tlast`, stay in RECV; otherwise go to DROP.
- **DROP:** discard all beats. A `tlast` beat returns the FSM to RECV and is not counted again.
- **Oversize frames** (more than DEPTH beats) always hit the full condition and are therefore dropped whole.
- **Read side:**
  - `dec_tvalid` = (`rd_ptr` != `commit_ptr`).
  - `dec_tdata` and `dec_tlast` come from the entry at `rd_ptr`.
  - `rd_ptr` +1 when `dec_tvalid` && `dec_tready`.
  - Uncommitted beats are never visible on the decoder side.
- **Handshake rule:** while `dec_tvalid` = 1 and `dec_tready` = 0, `dec_tdata` and `dec_tlast` must hold stable.
- **Counters** saturate at 16'hFFFF.

## Timing
- **Reset values:** `dec_tvalid` = 0; `dec_tdata` and `dec_tlast` = 0 (the memory is not reset, so gate these outputs with `dec_tvalid` or reset the read mux); all pointers = 0; state SYNC; both counters = 0.
- **Reset mid-frame:** in-flight and queued frames are lost. The post-reset tail fragment is absorbed by SYNC.
- **Latency:** if the `tlast` beat is written at edge N, `dec_tvalid` is high in the cycle after edge N and the first beat is presented then. Decoder-side throughput is 1 beat/cycle.
- **Same-cycle commit and read:** both happen. `dec_tvalid` stays continuous across back-to-back frames.
- **Same-cycle rollback and read:** the read is unaffected, because rollback never moves `wr_ptr` below `commit_ptr`.

## Configuration
- Macro `RX_BRIDGE_STATS_EN`.
  - **Defined:** `frame_count` and `drop_count` registers are instantiated and behave as described under Operation.
  - **Undefined:** no counter flops are built, and both ports are tied to 16'h0000.
- Data-path behaviour is identical in both builds.

## Structure
- **Shared package** (`rx_bridge_pkg`): the FSM state encoding (SYNC = 2'd0, RECV = 2'd1, DROP = 2'd2), the beat width constant (64) and the counter width constant (16).
- **Sub-module** (`rx_frame_fifo`): holds the memory and the three pointers, with push, commit, rollback and pop inputs. The write FSM and the stats stay in the top level.

## Test plan
- **Basic frame:** after reset plus one idle cycle, send a 3-beat frame 0x11, 0x22, 0x33 (tlast on 0x33, tuser = 0) with `dec_tready` = 1 -> the decoder sees 0x11, 0x22, 0x33 starting the cycle after the last write, with `dec_tlast` only on 0x33; `frame_count` = 1.
- **FCS error:** send a 4-beat frame with tuser = 1 on its last beat, followed by a good 2-beat frame -> only the 2-beat frame appears; `drop_count` = 1, `frame_count` = 1.
- **Overflow:** with DEPTH = 16 and `dec_tready` = 0, a 10-beat frame is committed; a second 10-beat frame then hits full at its 7th beat -> that frame is dropped, and raising `dec_tready` yields exactly the first 10 beats; `drop_count` = 1.
- **Oversize:** send a 17-beat frame into an empty FIFO -> nothing is presented; `drop_count` = 1; the following 1-beat frame passes.
- **Reset mid-frame:** assert `rst_n` low during beat 2 of 5, release it, then MAC beats 4 and 5 arrive (tlast on 5) -> both are discarded by SYNC; the next frame is delivered intact; counters = 0 before that next frame.
- **Back-pressure and back-to-back frames:** toggle `dec_tready` 1, 0, 1, 0 while two back-to-back 2-beat frames are read out -> data holds stable during stalls, all 4 beats arrive in order, and there are no gaps when `dec_tready` = 1.
